cdb_arbiter: RTL and testbench

- Arbitrates the single common data bus (CDB) that feeds the reorder buffer and reservation stations.
- Each execution unit (ALU, branch unit, AGU/misc) hands a finished result to a one-entry holding buffer; the arbiter broadcasts one result per cycle, round-robin, on registered CDB outputs.
- Sits between the functional units and the ROB's non-load CDB input; the load path keeps its own bus.
- Discards all in-flight results on a misbranch flush.

---
 rtl/cdb_arbiter.sv | 146 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the shared non-load CDB: one holding buffer per unit, one registered broadcast per cycle.
// Optional conflict counter enabled by defining CDB_ARB_PERF_EN.
module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      in_flush,
  input  logic [NUM_REQ-1:0]        in_req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  in_req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] in_req_value,
  input  logic [NUM_REQ-1:0]        in_req_isjump,
  input  logic [NUM_REQ*DATA_W-1:0] in_req_jump_addr,
  output logic [NUM_REQ-1:0]        out_req_ready,
  output logic [TAG_W-1:0]          out_cdb_rob_tag,
  output logic [DATA_W-1:0]         out_cdb_value,
  output logic                      out_cdb_isjump,
  output logic [DATA_W-1:0]         out_cdb_jump_addr,
  output logic [31:0]               out_perf_conflict_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] buf_valid;
  logic [TAG_W-1:0]   buf_tag       [NUM_REQ];
  logic [DATA_W-1:0]  buf_value     [NUM_REQ];
  logic [NUM_REQ-1:0] buf_isjump;
  logic [DATA_W-1:0]  buf_jump_addr [NUM_REQ];

  logic [PTR_W-1:0]   rr_ptr;
  logic [31:0]        rr_ext;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               any_grant;
  logic               advance;
  logic [NUM_REQ-1:0] tag_nz;
  logic [NUM_REQ-1:0] accept;

  assign advance = ena & ~in_flush;
  assign rr_ext  = 32'(rr_ptr);

  // Wrapping search split into two ascending passes: [rr_ptr..N-1] then [0..rr_ptr-1].
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_grant && buf_valid[i] && (i >= rr_ext)) begin
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
        any_grant = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_grant && buf_valid[i] && (i < rr_ext)) begin
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
        any_grant = 1'b1;
      end
    end
  end

  always_comb begin
    tag_nz = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      tag_nz[i] = |in_req_tag[i*TAG_W +: TAG_W];
    end
  end

  assign out_req_ready = {NUM_REQ{advance}} & (~buf_valid | grant);
  assign accept        = in_req_valid & out_req_ready & tag_nz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid  <= '0;
      buf_isjump <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        buf_tag[i]       <= '0;
        buf_value[i]     <= '0;
        buf_jump_addr[i] <= '0;
      end
    end else if (in_flush) begin
      buf_valid <= '0;
    end else if (ena) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          buf_valid[i]     <= 1'b1;
          buf_tag[i]       <= in_req_tag[i*TAG_W +: TAG_W];
          buf_value[i]     <= in_req_value[i*DATA_W +: DATA_W];
          buf_isjump[i]    <= in_req_isjump[i];
          buf_jump_addr[i] <= in_req_jump_addr[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr            <= '0;
      out_cdb_rob_tag   <= '0;
      out_cdb_value     <= '0;
      out_cdb_isjump    <= 1'b0;
      out_cdb_jump_addr <= '0;
    end else if (in_flush) begin
      out_cdb_rob_tag   <= '0;
      out_cdb_value     <= '0;
      out_cdb_isjump    <= 1'b0;
      out_cdb_jump_addr <= '0;
    end else if (ena) begin
      if (any_grant) begin
        out_cdb_rob_tag   <= buf_tag[grant_idx];
        out_cdb_value     <= buf_value[grant_idx];
        out_cdb_isjump    <= buf_isjump[grant_idx];
        out_cdb_jump_addr <= buf_jump_addr[grant_idx];
        rr_ptr            <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        out_cdb_rob_tag   <= '0;
        out_cdb_value     <= '0;
        out_cdb_isjump    <= 1'b0;
        out_cdb_jump_addr <= '0;
      end
    end
  end

`ifdef CDB_ARB_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt <= '0;
    end else if (advance && ($countones(buf_valid) > 1)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign out_perf_conflict_cnt = perf_cnt;
`else
  assign out_perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_cdb_arbiter;

  localparam int N  = 3;
  localparam int TW = 5;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            ena;
  logic            in_flush;
  logic [N-1:0]    in_req_valid;
  logic [N*TW-1:0] in_req_tag;
  logic [N*DW-1:0] in_req_value;
  logic [N-1:0]    in_req_isjump;
  logic [N*DW-1:0] in_req_jump_addr;
  logic [N-1:0]    out_req_ready;
  logic [TW-1:0]   out_cdb_rob_tag;
  logic [DW-1:0]   out_cdb_value;
  logic            out_cdb_isjump;
  logic [DW-1:0]   out_cdb_jump_addr;
  logic [31:0]     out_perf_conflict_cnt;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_flush(in_flush),
    .in_req_valid(in_req_valid), .in_req_tag(in_req_tag), .in_req_value(in_req_value),
    .in_req_isjump(in_req_isjump), .in_req_jump_addr(in_req_jump_addr),
    .out_req_ready(out_req_ready), .out_cdb_rob_tag(out_cdb_rob_tag),
    .out_cdb_value(out_cdb_value), .out_cdb_isjump(out_cdb_isjump),
    .out_cdb_jump_addr(out_cdb_jump_addr), .out_perf_conflict_cnt(out_perf_conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a slot per unit plus a "who goes next" index.
  bit            m_valid [N];
  logic [TW-1:0] m_tag   [N];
  logic [DW-1:0] m_val   [N];
  logic          m_isj   [N];
  logic [DW-1:0] m_addr  [N];
  int            m_next;
  logic [TW-1:0] m_cdb_tag;
  logic [DW-1:0] m_cdb_val;
  logic          m_cdb_isj;
  logic [DW-1:0] m_cdb_addr;
  logic [31:0]   m_perf;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
    m_next     = 0;
    m_cdb_tag  = '0;
    m_cdb_val  = '0;
    m_cdb_isj  = 1'b0;
    m_cdb_addr = '0;
    m_perf     = '0;
  endtask

  function automatic logic [31:0] exp_perf();
`ifdef CDB_ARB_PERF_EN
    return m_perf;
`else
    return 32'd0;
`endif
  endfunction

  task automatic check_cdb(input string name);
    chk({name, ".tag"}, 64'(out_cdb_rob_tag), 64'(m_cdb_tag));
    if (m_cdb_tag != '0) begin
      chk({name, ".val"}, 64'(out_cdb_value), 64'(m_cdb_val));
      chk({name, ".isj"}, 64'(out_cdb_isjump), 64'(m_cdb_isj));
      chk({name, ".addr"}, 64'(out_cdb_jump_addr), 64'(m_cdb_addr));
    end
    chk({name, ".perf"}, 64'(out_perf_conflict_cnt), 64'(exp_perf()));
  endtask

  // One clock: drive inputs at negedge, check ready, advance model, check registered outputs after posedge.
  task automatic cycle(input string name, input bit e, input bit f, input logic [N-1:0] v,
                       input logic [N*TW-1:0] t, input logic [N*DW-1:0] val,
                       input logic [N-1:0] j, input logic [N*DW-1:0] a);
    int g;
    int nv;
    logic [N-1:0] rdy;
    @(negedge clk);
    ena = e; in_flush = f; in_req_valid = v; in_req_tag = t;
    in_req_value = val; in_req_isjump = j; in_req_jump_addr = a;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && m_valid[(m_next + k) % N]) g = (m_next + k) % N;
    end
    for (int i = 0; i < N; i++) rdy[i] = e && !f && (!m_valid[i] || g == i);
    #1;
    chk({name, ".ready"}, 64'(out_req_ready), 64'(rdy));
    if (f) begin
      for (int i = 0; i < N; i++) m_valid[i] = 0;
      m_cdb_tag = '0; m_cdb_val = '0; m_cdb_isj = 1'b0; m_cdb_addr = '0;
    end else if (e) begin
      nv = 0;
      for (int i = 0; i < N; i++) nv += int'(m_valid[i]);
      if (nv >= 2) m_perf = m_perf + 32'd1;
      if (g >= 0) begin
        m_cdb_tag = m_tag[g]; m_cdb_val = m_val[g]; m_cdb_isj = m_isj[g]; m_cdb_addr = m_addr[g];
        m_valid[g] = 0;
        m_next = (g + 1) % N;
      end else begin
        m_cdb_tag = '0; m_cdb_val = '0; m_cdb_isj = 1'b0; m_cdb_addr = '0;
      end
      for (int i = 0; i < N; i++) begin
        if (v[i] && rdy[i] && t[i*TW +: TW] != '0) begin
          m_valid[i] = 1;
          m_tag[i]  = t[i*TW +: TW];
          m_val[i]  = val[i*DW +: DW];
          m_isj[i]  = j[i];
          m_addr[i] = a[i*DW +: DW];
        end
      end
    end
    @(posedge clk);
    #1;
    check_cdb(name);
  endtask

  task automatic idle(input string name);
    cycle(name, 1'b1, 1'b0, '0, '0, '0, '0, '0);
  endtask

  logic [N*TW-1:0] rt;
  logic [N*DW-1:0] rv, ra;
  logic [N-1:0]    rvld, rj;

  initial begin
    rst = 1'b0; ena = 1'b0; in_flush = 1'b0; in_req_valid = '0; in_req_tag = '0;
    in_req_value = '0; in_req_isjump = '0; in_req_jump_addr = '0;
    model_reset();
    @(posedge clk); #1;
    chk("rst.tag", 64'(out_cdb_rob_tag), 64'd0);
    chk("rst.val", 64'(out_cdb_value), 64'd0);
    chk("rst.isj", 64'(out_cdb_isjump), 64'd0);
    chk("rst.addr", 64'(out_cdb_jump_addr), 64'd0);
    chk("rst.perf", 64'(out_perf_conflict_cnt), 64'd0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 3; i++) idle("idle");
    chk("idle.ready", 64'(out_req_ready), 64'(3'b111));

    // Single request from unit 1.
    cycle("single", 1'b1, 1'b0, 3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'h1234, 32'd0},
          3'b010, {32'd0, 32'h80, 32'd0});
    chk("single.notyet", 64'(out_cdb_rob_tag), 64'd0);
    idle("single1");
    chk("single.tag", 64'(out_cdb_rob_tag), 64'd5);
    chk("single.val", 64'(out_cdb_value), 64'h1234);
    chk("single.isj", 64'(out_cdb_isjump), 64'd1);
    chk("single.addr", 64'(out_cdb_jump_addr), 64'h80);
    idle("single2");
    chk("single.after", 64'(out_cdb_rob_tag), 64'd0);

    // Back-to-back from unit 2 (leaves the round-robin index at 0).
    cycle("b2b1", 1'b1, 1'b0, 3'b100, {5'd1, 10'd0}, '0, '0, '0);
    cycle("b2b2", 1'b1, 1'b0, 3'b100, {5'd2, 10'd0}, '0, '0, '0);
    chk("b2b.t1", 64'(out_cdb_rob_tag), 64'd1);
    chk("b2b.rdy", 64'(out_req_ready[2]), 64'd1);
    cycle("b2b3", 1'b1, 1'b0, 3'b100, {5'd3, 10'd0}, '0, '0, '0);
    chk("b2b.t2", 64'(out_cdb_rob_tag), 64'd2);
    idle("b2b4");
    chk("b2b.t3", 64'(out_cdb_rob_tag), 64'd3);

    // Three-way conflict, then unit 0 re-offers tag 7 while being drained.
    cycle("c3a", 1'b1, 1'b0, 3'b111, {5'd6, 5'd4, 5'd3}, '0, '0, '0);
    cycle("c3b", 1'b1, 1'b0, 3'b001, {10'd0, 5'd7}, '0, '0, '0);
    chk("c3.t3", 64'(out_cdb_rob_tag), 64'd3);
    idle("c3c");
    chk("c3.t4", 64'(out_cdb_rob_tag), 64'd4);
    idle("c3d");
    chk("c3.t6", 64'(out_cdb_rob_tag), 64'd6);
    idle("c3e");
    chk("c3.t7", 64'(out_cdb_rob_tag), 64'd7);

    // Flush drops buffered 8 and 9; next index (1) survives the flush.
    cycle("fl1", 1'b1, 1'b0, 3'b011, {5'd0, 5'd9, 5'd8}, '0, '0, '0);
    cycle("fl2", 1'b1, 1'b1, 3'b000, '0, '0, '0, '0);
    chk("fl.tag", 64'(out_cdb_rob_tag), 64'd0);
    idle("fl3");
    chk("fl.none", 64'(out_cdb_rob_tag), 64'd0);
    cycle("fl4", 1'b1, 1'b0, 3'b101, {5'd12, 5'd0, 5'd11}, '0, '0, '0);
    idle("fl5");
    chk("fl.rr12", 64'(out_cdb_rob_tag), 64'd12);
    idle("fl6");
    chk("fl.rr11", 64'(out_cdb_rob_tag), 64'd11);

    // Stall with tag 10 buffered.
    cycle("st1", 1'b1, 1'b0, 3'b001, {10'd0, 5'd10}, {64'd0, 32'hABCD}, '0, '0);
    cycle("st2", 1'b0, 1'b0, 3'b000, '0, '0, '0, '0);
    chk("st.rdy", 64'(out_req_ready), 64'd0);
    cycle("st3", 1'b0, 1'b0, 3'b000, '0, '0, '0, '0);
    chk("st.hold", 64'(out_cdb_rob_tag), 64'd0);
    idle("st4");
    chk("st.t10", 64'(out_cdb_rob_tag), 64'd10);

    // Asynchronous reset between edges.
    @(negedge clk); #1; rst = 1'b0; #1;
    chk("arst.tag", 64'(out_cdb_rob_tag), 64'd0);
    chk("arst.val", 64'(out_cdb_value), 64'd0);
    chk("arst.perf", 64'(out_perf_conflict_cnt), 64'd0);
    #1; rst = 1'b1;
    model_reset();

    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        rvld[i] = ($urandom_range(0, 2) != 0);
        rt[i*TW +: TW] = ($urandom_range(0, 7) == 0) ? '0 : TW'($urandom_range(1, (1 << TW) - 1));
        rv[i*DW +: DW] = $urandom;
        ra[i*DW +: DW] = $urandom;
        rj[i] = $urandom_range(0, 1) == 1;
      end
      cycle("rnd", $urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, rvld, rt, rv, rj, ra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
